// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the EX-stage control and the multiply/divide unit.
// The master drives the request side; the unit (slave) drives busy/done and HI/LO.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_flush;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b, i_flush,
        input  o_busy, o_done, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_flush,
        output o_busy, o_done, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// combinationally from latched operands and committed when the latency counter expires.
module muldiv_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CW     = $clog2(MaxLat + 1);

    localparam logic [CW-1:0] MulCnt = CW'(MUL_LAT);
    localparam logic [CW-1:0] DivCnt = CW'(DIV_LAT);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMsub  = 3'b111;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic               w_is_mt;
    logic               w_is_div;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [2*WIDTH-1:0] w_hilo;
    logic [2*WIDTH-1:0] w_res;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_den_s;
    logic [WIDTH-1:0]   w_den_u;
    logic [WIDTH-1:0]   w_sq;
    logic [WIDTH-1:0]   w_sr;
    logic [WIDTH-1:0]   w_q_s;
    logic [WIDTH-1:0]   w_r_s;
    logic [WIDTH-1:0]   w_q_u;
    logic [WIDTH-1:0]   w_r_u;

    assign w_is_mt  = (bus.i_op[2:1] == 2'b10);
    assign w_is_div = (bus.i_op[2:1] == 2'b01);

    assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a})
                    * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
    assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
    assign w_hilo   = {r_hi, r_lo};

    // Signed divide on magnitudes; the most-negative / -1 case falls out naturally.
    assign w_a_neg  = r_a[WIDTH-1];
    assign w_b_neg  = r_b[WIDTH-1];
    assign w_b_zero = (r_b == '0);
    assign w_a_mag  = w_a_neg ? (-r_a) : r_a;
    assign w_b_mag  = w_b_neg ? (-r_b) : r_b;
    assign w_den_s  = w_b_zero ? WIDTH'(1) : w_b_mag;
    assign w_den_u  = w_b_zero ? WIDTH'(1) : r_b;
    assign w_sq     = w_a_mag / w_den_s;
    assign w_sr     = w_a_mag % w_den_s;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (-w_sq) : w_sq;
    assign w_r_s    = w_a_neg ? (-w_sr) : w_sr;
    assign w_q_u    = r_a / w_den_u;
    assign w_r_u    = r_a % w_den_u;

    always_comb begin
        w_res = w_hilo;
        unique case (r_op)
            OpMult:  w_res = w_prod_s;
            OpMultu: w_res = w_prod_u;
            OpMadd:  w_res = w_hilo + w_prod_s;
            OpMsub:  w_res = w_hilo - w_prod_s;
            OpDiv:   w_res = w_b_zero ? {r_a, {WIDTH{1'b1}}} : {w_r_s, w_q_s};
            OpDivu:  w_res = w_b_zero ? {r_a, {WIDTH{1'b1}}} : {w_r_u, w_q_u};
            default: w_res = w_hilo;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == StIdle) begin
                // Flush in IDLE suppresses any simultaneous request.
                if (bus.i_start && !bus.i_flush) begin
                    if (w_is_mt) begin
                        if (bus.i_op[0]) r_lo <= bus.i_a;
                        else             r_hi <= bus.i_a;
                    end else begin
                        r_op    <= bus.i_op;
                        r_a     <= bus.i_a;
                        r_b     <= bus.i_b;
                        r_cnt   <= w_is_div ? DivCnt : MulCnt;
                        r_state <= StRun;
                    end
                end
            end else if (bus.i_flush) begin
                r_state <= StIdle;
                r_cnt   <= '0;
            end else if (r_cnt == CW'(1)) begin
                {r_hi, r_lo} <= w_res;
                r_done       <= 1'b1;
                r_state      <= StIdle;
                r_cnt        <= '0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign bus.o_busy = (r_state == StRun);
    assign bus.o_done = r_done;
    assign bus.o_hi   = r_hi;
    assign bus.o_lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: literal expectations per operation plus an
// arithmetic reference model compared against the DUT on every cycle.
module tb_muldiv_unit;
    localparam int unsigned W       = 32;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMsub  = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(
        .WIDTH  (W),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit integers; returns {hi, lo}.
    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OpMult:  return 64'(sa * sb);
            OpMultu: return 64'(ua * ub);
            OpMadd:  return {hi, lo} + 64'(sa * sb);
            OpMsub:  return {hi, lo} - 64'(sa * sb);
            OpDiv: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OpDivu: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return {hi, lo};
        endcase
    endfunction

    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    int          m_left;
    logic        m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_res  <= '0;
            m_left <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (bus.i_flush) begin
                    m_left <= 0;
                end else if (m_left == 1) begin
                    m_left <= 0;
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.i_start && !bus.i_flush) begin
                case (bus.i_op)
                    OpMthi: m_hi <= bus.i_a;
                    OpMtlo: m_lo <= bus.i_a;
                    default: begin
                        m_res  <= model_res(bus.i_op, bus.i_a, bus.i_b, m_hi, m_lo);
                        m_left <= (bus.i_op[2:1] == 2'b01) ? int'(DIV_LAT) : int'(MUL_LAT);
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_busy", 64'(bus.o_busy), 64'(m_left != 0));
            check("cyc_done", 64'(bus.o_done), 64'(m_done));
            check("cyc_hi", 64'(bus.o_hi), 64'(m_hi));
            check("cyc_lo", 64'(bus.o_lo), 64'(m_lo));
        end
    end

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_a     = $urandom;
        bus.i_b     = $urandom;
    endtask

    task automatic wait_done(output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bus.o_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.o_busy) n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int lat);
        int n;
        bit seen;
        launch(op, a, b);
        wait_done(n, seen);
        check({name, "_done"}, 64'(seen), 64'd1);
        check({name, "_lat"}, 64'(n), 64'(lat));
        check({name, "_hi"}, 64'(bus.o_hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(bus.o_lo), 64'(exp_lo));
        check({name, "_mhi"}, 64'(m_hi), 64'(exp_hi));
        check({name, "_mlo"}, 64'(m_lo), 64'(exp_lo));
    endtask

    initial begin
        int n;
        bit seen;
        bus.i_start = 1'b0;
        bus.i_op    = '0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_flush = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.o_busy), 64'd0);
        check("rst_done", 64'(bus.o_done), 64'd0);
        check("rst_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
        rst_n = 1'b1;

        run_op("mult", OpMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT);
        run_op("multu", OpMultu, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, MUL_LAT);
        run_op("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT);
        run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_LAT);
        run_op("div_zero", OpDiv, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, DIV_LAT);
        run_op("divu_zero", OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT);

        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = OpMthi;
        bus.i_a     = 32'h10;
        @(negedge clk);
        bus.i_op    = OpMtlo;
        bus.i_a     = 32'h20;
        @(negedge clk);
        bus.i_start = 1'b0;
        check("mt_hi", 64'(bus.o_hi), 64'h10);
        check("mt_lo", 64'(bus.o_lo), 64'h20);
        check("mt_busy", 64'(bus.o_busy), 64'd0);

        // 0x10_00000020 - 33 borrows out of LO.
        run_op("madd", OpMadd, 32'hFFFF_FFFF, 32'h21, 32'hF, 32'hFFFF_FFFF, MUL_LAT);
        run_op("msub", OpMsub, 32'd1, 32'd1, 32'hF, 32'hFFFF_FFFE, MUL_LAT);

        launch(OpMult, 32'd3, 32'd4);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = OpMtlo;
        bus.i_a     = 32'hAA;
        @(negedge clk);
        bus.i_start = 1'b0;
        wait_done(n, seen);
        check("mtlo_busy_done", 64'(seen), 64'd1);
        check("mtlo_busy_hi", 64'(bus.o_hi), 64'd0);
        check("mtlo_busy_lo", 64'(bus.o_lo), 64'd12);

        launch(OpDiv, 32'd50, 32'd7);
        repeat (3) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        check("flush_busy", 64'(bus.o_busy), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.o_done) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_nodone", 64'(seen), 64'd0);
        check("flush_hilo", {bus.o_hi, bus.o_lo}, 64'd12);

        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = OpMthi;
        bus.i_a     = 32'h55;
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        check("idle_flush_hi", 64'(bus.o_hi), 64'd0);
        check("idle_flush_busy", 64'(bus.o_busy), 64'd0);

        launch(OpDiv, 32'd50, 32'd7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstrun_hilo", {bus.o_hi, bus.o_lo}, 64'd0);
        check("rstrun_busy", 64'(bus.o_busy), 64'd0);
        check("rstrun_done", 64'(bus.o_done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_after", OpMultu, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
